// File: rtl/adc_scan_ctrl_if.sv
// ============================================================================
// Module      : adc_scan_ctrl_if
// Description : Converter strobe/data bundle and host result/status bundle
//               for the multi-channel ADC scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_scan_ctrl_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    logic              init;
    logic              EOC;
    logic [DW-1:0]     datain;
    logic              CLK1;
    logic              ALE;
    logic              START;
    logic              OE_R;
    logic [2:0]        add;
    logic [NCH*DW-1:0] samples;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  init, EOC, datain,
        output CLK1, ALE, START, OE_R, add, samples, busy, done, err
    );

    modport slave (
        output init, EOC, datain,
        input  CLK1, ALE, START, OE_R, add, samples, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Sequential multi-channel ADC scanner (ALE/START, EOC wait with
//               timeout, OE read) plus free-running divided converter clock.
//               Define ADC_SCAN_CONT_EN for continuous scanning while init=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_scan_ctrl #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int DIV     = 4,
    parameter int START_W = 2,
    parameter int OE_W    = 2,
    parameter int TMO     = 1023
) (
    input  logic           CLK,
    input  logic           RST_N,
    adc_scan_ctrl_if.master bus
);

    localparam int c_ch_w    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_div_w   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_cnt_max = (TMO > START_W) ? ((TMO > OE_W) ? TMO : OE_W)
                                               : ((START_W > OE_W) ? START_W : OE_W);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_STRT  = 3'd2,
        S_EOCL  = 3'd3,
        S_EOCH  = 3'd4,
        S_READ  = 3'd5,
        S_STORE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_div_w-1:0]  r_div;
    logic                r_clk1;
    logic                r_eoc_s1;
    logic                r_eoc_s2;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_ch_w-1:0]   r_ch;
    logic [DW-1:0]       r_data;
    logic [NCH*DW-1:0]   r_samples;
    logic                r_err;

    logic                w_eoc;
    logic                w_start;
    logic                w_tmo;
    logic                w_rd_last;
    logic                w_last_ch;
    logic                w_strobe;
    logic                w_oe;
    logic                w_busy;
    logic                w_done;

    // Divider runs regardless of scan state so the converter always sees a steady clock
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div  <= '0;
            r_clk1 <= 1'b0;
        end else if (r_div == c_div_w'(DIV - 1)) begin
            r_div  <= '0;
            r_clk1 <= ~r_clk1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_eoc_s1 <= 1'b0;
            r_eoc_s2 <= 1'b0;
        end else begin
            r_eoc_s1 <= bus.EOC;
            r_eoc_s2 <= r_eoc_s1;
        end
    end

    assign w_eoc     = r_eoc_s2;
    assign w_last_ch = (r_ch == c_ch_w'(NCH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_tmo       = 1'b0;
        w_rd_last   = 1'b0;
        w_strobe    = 1'b0;
        w_oe        = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.init) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: w_state_nxt = S_STRT;
            S_STRT: begin
                w_strobe = 1'b1;
                if (r_cnt == c_cnt_w'(START_W - 1)) w_state_nxt = S_EOCL;
            end
            S_EOCL: begin
                if (!w_eoc) begin
                    w_state_nxt = S_EOCH;
                end else if (r_cnt == c_cnt_w'(TMO - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_STORE;
                end
            end
            S_EOCH: begin
                if (w_eoc) begin
                    w_state_nxt = S_READ;
                end else if (r_cnt == c_cnt_w'(TMO - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_STORE;
                end
            end
            S_READ: begin
                w_oe = 1'b1;
                if (r_cnt == c_cnt_w'(OE_W - 1)) begin
                    w_rd_last   = 1'b1;
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: w_state_nxt = w_last_ch ? S_DONE : S_ADDR;
            S_DONE: begin
                w_done = 1'b1;
`ifdef ADC_SCAN_CONT_EN
                w_state_nxt = bus.init ? S_ADDR : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state cycle counter restarts on every state change
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ch      <= '0;
            r_data    <= '0;
            r_samples <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_start) begin
                r_ch  <= '0;
                r_err <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_ch  <= '0;
            end else if (r_state == S_STORE && !w_last_ch) begin
                r_ch  <= r_ch + 1'b1;
            end

            if (w_tmo) begin
                r_err  <= 1'b1;
                r_data <= '0;
            end else if (w_rd_last) begin
                r_data <= bus.datain;
            end

            // Only the active slot is written; the rest keep their last-scan values
            if (r_state == S_STORE) begin
                for (int k = 0; k < NCH; k++) begin
                    if (r_ch == c_ch_w'(k)) r_samples[k*DW +: DW] <= r_data;
                end
            end
        end
    end

    assign bus.CLK1    = r_clk1;
    assign bus.ALE     = w_strobe;
    assign bus.START   = w_strobe;
    assign bus.OE_R    = w_oe;
    assign bus.add     = 3'(r_ch);
    assign bus.samples = r_samples;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// ============================================================================
// Module      : tb_adc_scan_ctrl
// Description : Directed self-checking bench for adc_scan_ctrl with a simple
//               behavioural converter model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_scan_ctrl;

    localparam int NCH     = 4;
    localparam int DW      = 8;
    localparam int DIV     = 4;
    localparam int START_W = 2;
    localparam int OE_W    = 2;
    localparam int TMO     = 1023;

`ifdef ADC_SCAN_CONT_EN
    localparam logic c_gap_busy = 1'b1;
`else
    localparam logic c_gap_busy = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    adc_scan_ctrl_if #(.NCH(NCH), .DW(DW)) u_if ();

    adc_scan_ctrl #(
        .NCH(NCH), .DW(DW), .DIV(DIV),
        .START_W(START_W), .OE_W(OE_W), .TMO(TMO)
    ) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (u_if)
    );

    always #5 CLK = ~CLK;

    // Converter model: START pulls EOC low; it returns high a few cycles later
    logic [7:0] val [8];
    int         no_eoc_ch = 8;
    int         eoc_cnt   = 0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            u_if.EOC <= 1'b1;
            eoc_cnt  <= 0;
        end else if (u_if.START) begin
            u_if.EOC <= 1'b0;
            eoc_cnt  <= (int'(u_if.add) == no_eoc_ch) ? 0 : 6;
        end else if (eoc_cnt > 0) begin
            eoc_cnt <= eoc_cnt - 1;
            if (eoc_cnt == 1) u_if.EOC <= 1'b1;
        end
    end

    assign u_if.datain = u_if.OE_R ? val[u_if.add] : 8'h00;

    // Protocol monitor
    int         cyc = 0;
    int         clk1_rises = 0, clk1_bad = 0, clk1_last = 0;
    bit         clk1_v = 0;
    logic       clk1_prev = 0, ale_prev = 0;
    int         ale_runs = 0, ale_bad = 0, ale_len = 0;
    int         oe_runs = 0, oe_bad = 0, oe_len = 0;
    int         strobe_mis = 0, done_cnt = 0;
    logic [2:0] add_log [$];

    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            clk1_v = 0; clk1_prev = 0; ale_prev = 0; ale_len = 0; oe_len = 0;
        end else begin
            if (u_if.CLK1 && !clk1_prev) begin
                if (clk1_v && (cyc - clk1_last) != 2*DIV) clk1_bad++;
                clk1_rises++;
                clk1_last = cyc;
                clk1_v    = 1;
            end
            if (u_if.ALE) begin
                if (!ale_prev) add_log.push_back(u_if.add);
                ale_len++;
            end else if (ale_len > 0) begin
                ale_runs++;
                if (ale_len != START_W) ale_bad++;
                ale_len = 0;
            end
            if (u_if.OE_R) begin
                oe_len++;
            end else if (oe_len > 0) begin
                oe_runs++;
                if (oe_len != OE_W) oe_bad++;
                oe_len = 0;
            end
            if (u_if.ALE !== u_if.START) strobe_mis++;
            if (u_if.done) done_cnt++;
            clk1_prev = u_if.CLK1;
            ale_prev  = u_if.ALE;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (u_if.done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_oe(input string tag, input logic [2:0] ch, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (u_if.OE_R && u_if.add == ch) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic set_vals(input logic [7:0] base);
        for (int k = 0; k < 8; k++) val[k] = base + 8'(k);
    endtask

    task automatic pulse_init();
        u_if.init = 1'b1;
        @(negedge CLK);
        u_if.init = 1'b0;
    endtask

    int d0, a0, ab0, o0, ob0, n0;

    initial begin
        u_if.init = 1'b0;
        set_vals(8'h10);

        // Reset state
        repeat (4) @(negedge CLK);
        chk("rst_outputs",
            {u_if.ALE, u_if.START, u_if.OE_R, u_if.add, u_if.samples,
             u_if.busy, u_if.done, u_if.err, u_if.CLK1}, 64'd0);

        // Divided clock after release
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("clk1_p3", u_if.CLK1, 1'b0);
        @(negedge CLK);
        chk("clk1_p4", u_if.CLK1, 1'b1);
        repeat (3) @(negedge CLK);
        chk("clk1_p7", u_if.CLK1, 1'b1);
        @(negedge CLK);
        chk("clk1_p8", u_if.CLK1, 1'b0);

        // Basic single scan
        d0 = done_cnt; a0 = ale_runs; ab0 = ale_bad; o0 = oe_runs; ob0 = oe_bad;
        n0 = add_log.size();
        pulse_init();
        chk("t1_busy", u_if.busy, 1'b1);
        chk("t1_add0", u_if.add, 3'd0);
        wait_done("t1_done_seen", 500);
        chk("t1_samples", u_if.samples, 32'h13121110);
        chk("t1_err", u_if.err, 1'b0);
        @(negedge CLK);
        chk("t1_done_low", u_if.done, 1'b0);
        chk("t1_idle", u_if.busy, 1'b0);
        @(negedge CLK);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_ale_runs", ale_runs - a0, NCH);
        chk("t1_ale_width", ale_bad - ab0, 0);
        chk("t1_oe_runs", oe_runs - o0, NCH);
        chk("t1_oe_width", oe_bad - ob0, 0);
        chk("t1_strobe_eq", strobe_mis, 0);
        chk("t1_add_cnt", add_log.size() - n0, NCH);
        if (add_log.size() >= n0 + NCH)
            for (int i = 0; i < NCH; i++) chk("t1_add_seq", add_log[n0+i], 3'(i));

        // EOC never returns on channel 2
        set_vals(8'h30);
        no_eoc_ch = 2;
        d0 = done_cnt;
        pulse_init();
        wait_done("t2_done_seen", 3000);
        chk("t2_err", u_if.err, 1'b1);
        chk("t2_samples", u_if.samples, 32'h33003130);
        no_eoc_ch = 8;
        @(negedge CLK);
        chk("t2_err_sticky", u_if.err, 1'b1);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // init held high across two scans
        set_vals(8'h60);
        d0 = done_cnt;
        u_if.init = 1'b1;
        @(negedge CLK);
        chk("t3_busy", u_if.busy, 1'b1);
        chk("t3_err_clr", u_if.err, 1'b0);
        wait_done("t3_done1_seen", 500);
        chk("t3_samples1", u_if.samples, 32'h63626160);
        set_vals(8'hA0);
        @(negedge CLK);
        chk("t3_gap_busy", u_if.busy, c_gap_busy);
        @(negedge CLK);
        chk("t3_busy2", u_if.busy, 1'b1);
        wait_oe("t3_oe2_seen", 3'd2, 500);
        chk("t3_partial", u_if.samples, 32'h6362A1A0);
        wait_done("t3_done2_seen", 500);
        u_if.init = 1'b0;
        chk("t3_samples2", u_if.samples, 32'hA3A2A1A0);
        repeat (2) @(negedge CLK);
        chk("t3_idle", u_if.busy, 1'b0);
        chk("t3_done_cnt", done_cnt - d0, 2);

        // Reset during channel 1 read
        set_vals(8'h50);
        pulse_init();
        wait_oe("t4_oe1_seen", 3'd1, 500);
        d0 = done_cnt;
        RST_N = 1'b0;
        #1;
        chk("t4_rst_outputs",
            {u_if.ALE, u_if.START, u_if.OE_R, u_if.add, u_if.samples,
             u_if.busy, u_if.done, u_if.err, u_if.CLK1}, 64'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_resume", u_if.busy, 1'b0);
        pulse_init();
        wait_done("t4_done_seen", 500);
        chk("t4_samples", u_if.samples, 32'h53525150);
        chk("t4_err", u_if.err, 1'b0);

        repeat (2) @(negedge CLK);
        chk("clk1_period", clk1_bad, 0);
        chk("clk1_active", 64'(clk1_rises > 20), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of scanned channels (1..8).
REQ-002 SHALL have parameter DW, default 8, converter data width.
REQ-003 SHALL have parameter DIV, default 4, ADC clock half-period in CLK cycles (>=1).
REQ-004 SHALL have parameter START_W, default 2, ALE/START pulse width in CLK cycles.
REQ-005 SHALL have parameter OE_W, default 2, OE pulse width in CLK cycles.
REQ-006 SHALL have parameter TMO, default 1023, EOC wait limit in CLK cycles per phase.
REQ-007 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-009 SHALL have port init  input  1  scan request, level-sampled in IDLE.
REQ-010 SHALL have port EOC  input  1  converter end-of-conversion, asynchronous.
REQ-011 SHALL have port datain  input  DW  converter output bus.
REQ-012 SHALL have port CLK1  output  1  divided converter clock.
REQ-013 SHALL have ports ALE, START, OE_R  output  1 each  converter strobes.
REQ-014 SHALL have port add  output  3  converter mux address.
REQ-015 SHALL have port samples  output  NCH*DW  channel k at bits [k*DW +: DW].
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at scan end.
REQ-018 SHALL have port err  output  1  sticky EOC-timeout flag.

Function
REQ-019 SHALL toggle CLK1 every DIV CLK cycles, free-running, independent of the state machine.
REQ-020 SHALL synchronise EOC through two flops; all EOC decisions use the synchronised value.
REQ-021 SHALL implement states IDLE, ADDR, STRT, EOCL, EOCH, READ, STORE, DONE.
REQ-022 IDLE: init=1 -> ADDR next cycle, channel index ch=0, err cleared.
REQ-023 ADDR: add=ch for 1 cycle (address setup), then STRT; add holds ch until STORE.
REQ-024 STRT: ALE=START=1 for exactly START_W cycles, then EOCL.
REQ-025 EOCL: wait synchronised EOC=0, then EOCH; EOCH: wait EOC=1, then READ.
REQ-026 Timeout: if EOCL or EOCH lasts TMO cycles, set err, go to STORE with data value 0.
REQ-027 READ: OE_R=1 for exactly OE_W cycles; datain captured on last OE cycle.
REQ-028 STORE: write captured value to samples slot ch; if ch==NCH-1 -> DONE, else ch+1 -> ADDR.
REQ-029 DONE: done=1 for one cycle, then IDLE (or ADDR, see Configuration).
REQ-030 samples slots not yet written in the current scan SHALL hold their previous-scan values.
REQ-031 init asserted while busy SHALL be ignored; init held high in IDLE starts a new scan each time IDLE is entered.
REQ-032 Per-channel minimum latency ADDR->STORE = 1+START_W+2(sync)+OE_W+EOC cycles; no extra idle cycles between channels.
REQ-033 add upper bits SHALL be zero when NCH<=4 values are exceeded never; ch never exceeds NCH-1.

Reset
REQ-034 RST_N=0 SHALL immediately force IDLE, ch=0, samples=0, ALE=START=OE_R=0, add=0, busy=0, done=0, err=0, CLK1=0, sync flops=0.
REQ-035 Reset mid-scan SHALL abort without done pulse; operation resumes only on init after release.

Configuration
REQ-036 Macro ADC_SCAN_CONT_EN defined: DONE returns directly to ADDR with ch=0 (continuous scanning) while init=1; init=0 at DONE -> IDLE.
REQ-037 Macro ADC_SCAN_CONT_EN undefined: DONE always returns to IDLE (single-shot), regardless of init.

Verification
REQ-038 Reset then init pulse, model returns channel k value 8'h10+k -> samples=32'h13121110, one done pulse, err=0.
REQ-039 START_W=2, OE_W=2: check ALE/START high exactly 2 cycles, OE_R exactly 2 cycles, add=0,1,2,3 in order.
REQ-040 Model never raises EOC on channel 2 -> after TMO cycles err=1, samples[23:16]=0, channels 0,1,3 valid, done pulses.
REQ-041 RST_N low during channel 1 READ -> all outputs zero next evaluation, no done; new init gives full correct scan.
REQ-042 init held high, second scan with new data 8'hA0+k: with ADC_SCAN_CONT_EN no IDLE cycle between scans; without, busy low one cycle between scans; samples=32'hA3A2A1A0.
REQ-043 DIV=4: CLK1 period 8 CLK cycles, unaffected by scan start, reset release CLK1=0.
